uc_seq: RTL
===========

# uc_seq

Sequencing control unit for the single-cycle microcontroller datapath `microc`. It decodes the 6-bit `Opcode` and the registered zero flag `z` into the datapath controls `s_inc`, `s_inm`, `we3`, `wez` and `Op`. It also gates the whole machine through a run/stop/single-step state machine and counts retired instructions. It sits beside `microc` in the top level. The PC register enable is driven by `pc_en` from this block instead of a constant 1.

## Interface
Parameters:
- `CNT_W`, 16: width of the retired-instruction counter.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `Opcode`  in  6  `instr[15:10]` from the datapath.
- `z`  in  1  registered zero flag from the datapath.
- `start`  in  1  level; requests IDLE→RUN.
- `stop`  in  1  level; requests RUN→IDLE and has priority over `start`.
- `step_mode`  in  1  1 = execute only on a `step` rising edge.
- `step`  in  1  single-step request; its rising edge is detected internally.
- `s_inc`  out  1  PC mux select: 1 = load `instr[9:0]`, 0 = PC+1.
- `s_inm`  out  1  register-file write-data select: 1 = immediate.
- `we3`  out  1  register-file write enable.
- `wez`  out  1  z-flag register enable.
- `Op`  out  3  ALU operation.
- `pc_en`  out  1  PC register enable.
- `running`  out  1  state == RUN.
- `halted`  out  1  state == HALTED.
- `illegal`  out  1  sticky: an undefined opcode was executed.
- `icount`  out  CNT_W  retired instructions; saturating.

## Operation
Opcode classes:
- `Opcode[5]=1`: ALU instruction.
  - `Op=Opcode[4:2]`, `we3=1`, `wez=1`, `s_inm=0`, `s_inc=0`.
- `Opcode[5:4]=00`: LI (load immediate).
  - `s_inm=1`, `we3=1`, `wez=0`, `s_inc=0`.
- `Opcode[5:4]=01`: jump class; sub-code is `Opcode[3:0]`. All jump-class instructions drive `we3=0`, `wez=0`.
  - `0000` J: `s_inc=1`.
  - `0001` JZ: `s_inc=z`.
  - `0010` JNZ: `s_inc=~z`.
  - `0011` HALT: `pc_en=0`.
  - `0100`–`1111`: illegal. Executes as a NOP (PC+1) and sets `illegal`.
- When no execution occurs, `Op=000`.

Execute gate:
- `exec = (state==RUN) & ~stop & (~step_mode | step_rise)`.
- `step_rise = step & ~step_q`. `step_q` is a register sampled every cycle.
- When `exec=0`: `pc_en`, `we3`, `wez`, `s_inc` and `s_inm` are all 0, so the datapath holds its state.
- When `exec=1`: outputs follow the decode above, and `pc_en=1` except for HALT.

State machine (states IDLE, RUN, HALTED):
- IDLE: `start & ~stop` → RUN. Otherwise stays in IDLE.
- RUN: `stop` → IDLE, and no instruction executes that cycle. `exec` on HALT → HALTED. Otherwise stays in RUN.
- HALTED: terminal. Only `reset` leaves it; `start` is ignored.

Counters and flags:
- `icount` increments on every `exec` cycle except HALT.
- `icount` holds at all-ones once reached.
- `illegal` is set on an `exec` cycle with an illegal sub-code and clears only on reset.

## Timing
- Reset (asynchronous) values:
  - state = IDLE; `step_q=0`; `icount=0`; `illegal=0`.
  - All control outputs 0; `running=0`; `halted=0`.
- Decode to control outputs is combinational within the same cycle, matching the single-cycle datapath. Register writes and the PC update occur at the next edge.
- Start latency: `start` sampled high in IDLE → `running=1` after the next edge → the first instruction executes in that cycle.
- Stop is immediate: `stop` high in RUN suppresses that cycle's execution, and the state is IDLE after the edge.
- A step held high executes exactly one instruction. A new pulse needs `step` low for at least one cycle.
- `step_mode` changes take effect in the same cycle.
- HALT cycle: `pc_en=0`, so the PC stays on the HALT address. `halted=1` after the edge.
- Reset mid-instruction aborts it. No register write occurs, because reset is asynchronous and the outputs go to 0.

## Structure
- Package `microc_pkg` holds:
  - the state enum `uc_state_t` (IDLE, RUN, HALTED);
  - opcode class constants `OPC_ALU`, `OPC_LI`, `OPC_JMP`;
  - jump sub-code constants `JC_J`, `JC_JZ`, `JC_JNZ`, `JC_HALT`.
- Sub-module `uc_dec` is purely combinational. It maps `Opcode`/`z` to raw controls plus `is_halt` and `is_illegal`.
- `uc_seq` wraps `uc_dec` with the FSM, step edge detector, execute gating, counter and sticky flag.

## Test plan
- Reset, then `start` one cycle → `running=1` next cycle. `Opcode=6'b101000` (ALU op 010) gives `Op=010`, `we3=1`, `wez=1`, `pc_en=1`; `icount` goes 0→1.
- Opcode `000000` (LI) → `s_inm=1`, `we3=1`, `wez=0`. JZ (`010001`):
  - with `z=1` → `s_inc=1`;
  - with `z=0` → `s_inc=0`;
  - JNZ (`010010`) gives the inverse for the same two `z` values.
- HALT (`010011`) in RUN → `pc_en=0`, `we3=0`, `halted=1` after the edge, `icount` unchanged. A later `start` leaves `halted=1`.
- `step_mode=1` with `step` held high for 5 cycles → exactly one execution (`icount` +1). Two separate 1-cycle pulses → +2.
- Opcode `010111` executed → `illegal=1`, `s_inc=0`, `pc_en=1`. `illegal` stays 1 across later legal instructions until reset.
- `stop` and `start` both high in IDLE → stays IDLE. `icount` preloaded by 65535 ALU cycles (`CNT_W=16`) → reads 16'hFFFF and holds there. Async `reset` mid-RUN → all outputs 0 immediately, without waiting for `clk`.

Source files
------------

// File: rtl/microc_pkg.sv
// rtl/microc_pkg.sv - shared types and opcode constants for the microc sequencer
package microc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_HALTED = 2'b10
  } uc_state_t;

  // OPC_ALU is matched against Opcode[5] alone; the others against Opcode[5:4]
  localparam logic       OPC_ALU = 1'b1;
  localparam logic [1:0] OPC_LI  = 2'b00;
  localparam logic [1:0] OPC_JMP = 2'b01;

  localparam logic [3:0] JC_J    = 4'b0000;
  localparam logic [3:0] JC_JZ   = 4'b0001;
  localparam logic [3:0] JC_JNZ  = 4'b0010;
  localparam logic [3:0] JC_HALT = 4'b0011;

endpackage

// File: rtl/uc_dec.sv
// rtl/uc_dec.sv - combinational opcode decoder producing raw (ungated) datapath controls
module uc_dec
  import microc_pkg::*;
(
  input  logic [5:0] Opcode,
  input  logic       z,
  output logic       s_inc,
  output logic       s_inm,
  output logic       we3,
  output logic       wez,
  output logic [2:0] Op,
  output logic       is_halt,
  output logic       is_illegal
);

  always_comb begin
    s_inc      = 1'b0;
    s_inm      = 1'b0;
    we3        = 1'b0;
    wez        = 1'b0;
    Op         = 3'b000;
    is_halt    = 1'b0;
    is_illegal = 1'b0;
    if (Opcode[5] == OPC_ALU) begin
      Op  = Opcode[4:2];
      we3 = 1'b1;
      wez = 1'b1;
    end else if (Opcode[5:4] == OPC_LI) begin
      s_inm = 1'b1;
      we3   = 1'b1;
    end else if (Opcode[5:4] == OPC_JMP) begin
      // undefined sub-codes fall through as a NOP with PC+1
      case (Opcode[3:0])
        JC_J:    s_inc = 1'b1;
        JC_JZ:   s_inc = z;
        JC_JNZ:  s_inc = ~z;
        JC_HALT: is_halt = 1'b1;
        default: is_illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/uc_seq.sv
// rtl/uc_seq.sv - run/stop/step sequencer gating the microc control decode
module uc_seq
  import microc_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       Opcode,
  input  logic             z,
  input  logic             start,
  input  logic             stop,
  input  logic             step_mode,
  input  logic             step,
  output logic             s_inc,
  output logic             s_inm,
  output logic             we3,
  output logic             wez,
  output logic [2:0]       Op,
  output logic             pc_en,
  output logic             running,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] icount
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  uc_state_t  state, state_nxt;
  logic       step_q;
  logic       step_rise;
  logic       exec;
  logic       d_s_inc, d_s_inm, d_we3, d_wez, d_halt, d_illegal;
  logic [2:0] d_op;

  uc_dec u_dec (
    .Opcode     (Opcode),
    .z          (z),
    .s_inc      (d_s_inc),
    .s_inm      (d_s_inm),
    .we3        (d_we3),
    .wez        (d_wez),
    .Op         (d_op),
    .is_halt    (d_halt),
    .is_illegal (d_illegal)
  );

  assign step_rise = step & ~step_q;
  assign exec      = (state == ST_RUN) & ~stop & (~step_mode | step_rise);

  // with exec low every enable drops so the datapath holds its state
  assign s_inc   = exec & d_s_inc;
  assign s_inm   = exec & d_s_inm;
  assign we3     = exec & d_we3;
  assign wez     = exec & d_wez;
  assign Op      = exec ? d_op : 3'b000;
  assign pc_en   = exec & ~d_halt;
  assign running = (state == ST_RUN);
  assign halted  = (state == ST_HALTED);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (start && !stop) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (stop) state_nxt = ST_IDLE;
        else if (exec && d_halt) state_nxt = ST_HALTED;
      end
      ST_HALTED: state_nxt = ST_HALTED;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      step_q  <= 1'b0;
      icount  <= '0;
      illegal <= 1'b0;
    end else begin
      step_q <= step;
      if (exec && !d_halt && (icount != {CNT_W{1'b1}})) begin
        icount <= icount + CNT_ONE;
      end
      if (exec && d_illegal) begin
        illegal <= 1'b1;
      end
    end
  end

endmodule
